// File: rtl/aes256_decrypt_core_if.sv
// ----------------------------------------------------------------------------
// aes256_decrypt_core_if
// Request/response bundle between the AES-256 decryption core and its user.
//   start      : request to decrypt (sampled by the core only while idle)
//   ciphertext : 128-bit input block, byte 0 in bits [127:120]
//   rk_idx     : index 0..14 of the round key the core needs this cycle
//   rk_in      : round key for rk_idx, combinational from the key store
//   plaintext  : registered result, same byte order as ciphertext
//   done       : one-cycle pulse, plaintext valid from this cycle
//   busy       : high while a block is being processed
// master = requester / key store side, slave = the decryption core.
// ----------------------------------------------------------------------------
interface aes256_decrypt_core_if;
  logic         start;
  logic [127:0] ciphertext;
  logic [3:0]   rk_idx;
  logic [127:0] rk_in;
  logic [127:0] plaintext;
  logic         done;
  logic         busy;

  modport master (
    output start, ciphertext, rk_in,
    input  rk_idx, plaintext, done, busy
  );

  modport slave (
    input  start, ciphertext, rk_in,
    output rk_idx, plaintext, done, busy
  );
endinterface

// File: rtl/aes256_decrypt_core.sv
// ----------------------------------------------------------------------------
// aes256_decrypt_core
// Iterative AES-256 inverse cipher, one round per clock. Round keys are not
// stored here: the core publishes rk_idx and consumes rk_in in the same cycle.
// Sequence after an accepted start: INIT (AddRoundKey rk14), 13 x ROUND
// (rk13..rk1), FINAL (rk0, no InvMixColumns), DONE (done pulse).
// Ports:
//   clk    : clock, all state updates on the rising edge
//   rst_n  : asynchronous active-low reset
//   io_bus : aes256_decrypt_core_if.slave (start, ciphertext, rk_idx, rk_in,
//            plaintext, done, busy)
// ----------------------------------------------------------------------------

// Inverse S-box, one byte. Pure lookup into a constant table.
module inv_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  // NOTE: a constant table holds no state, so there is nothing to reset here.
  localparam logic [2047:0] C_TABLE = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  // Entry x sits at bits [8*(255-x) +: 8]; for a byte, ~x equals 255-x.
  assign o_byte = C_TABLE[{~i_byte, 3'b000} +: 8];
endmodule

module aes256_decrypt_core (
  input logic                   clk,
  input logic                   rst_n,
  aes256_decrypt_core_if.slave  io_bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_INIT  = 3'd1;
  localparam logic [2:0] S_ROUND = 3'd2;
  localparam logic [2:0] S_FINAL = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]   r_fsm;
  logic [3:0]   r_cnt;
  logic [127:0] r_state;
  logic [127:0] r_plaintext;

  logic [127:0] w_shifted;
  logic [127:0] w_subbed;
  logic [127:0] w_added;
  logic [127:0] w_mixed;
  logic [3:0]   w_rk_idx;
  logic         w_busy;
  logic         w_done;

  // GF(2^8) doubling, reduction polynomial 0x11B.
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One column of InvMixColumns; s0 is the most significant byte.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] s [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      s[i]  = col[31-8*i -: 8];
      x2    = xt(s[i]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[i] = x8 ^ s[i];
      mb[i] = x8 ^ x2 ^ s[i];
      md[i] = x8 ^ x4 ^ s[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  // InvShiftRows: row r of column c takes the byte from column (c - r) mod 4.
  // Byte index 4*c + r lives at bits [127 - 8*(4*c + r) -: 8].
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int SRC = 4 * ((c + 4 - r) % 4) + r;
      assign w_shifted[127-8*(4*c+r) -: 8] = r_state[127-8*SRC -: 8];
    end
  end

  for (genvar k = 0; k < 16; k++) begin : g_isb
    inv_sbox u_inv_sbox (
      .i_byte (w_shifted[127-8*k -: 8]),
      .o_byte (w_subbed[127-8*k -: 8])
    );
  end

  // The round key is applied before InvMixColumns (standard inverse cipher,
  // not the equivalent inverse cipher), so rk_in is used unmodified.
  assign w_added = w_subbed ^ io_bus.rk_in;

  for (genvar c = 0; c < 4; c++) begin : g_imc
    assign w_mixed[127-32*c -: 32] = inv_mix_col(w_added[127-32*c -: 32]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      r_fsm       <= S_IDLE;
      r_cnt       <= 4'd0;
      r_state     <= '0;
      r_plaintext <= '0;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          if (io_bus.start) begin
            r_state <= io_bus.ciphertext;
            r_cnt   <= 4'd13;
            r_fsm   <= S_INIT;
          end
        end
        S_INIT: begin
          r_state <= r_state ^ io_bus.rk_in;
          r_fsm   <= S_ROUND;
        end
        S_ROUND: begin
          r_state <= w_mixed;
          r_cnt   <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_fsm <= S_FINAL;
        end
        S_FINAL: begin
          r_plaintext <= w_added;
          r_fsm       <= S_DONE;
        end
        S_DONE:  r_fsm <= S_IDLE;
        default: r_fsm <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns w_rk_idx and no latch appears.
    w_rk_idx = 4'd14;
    case (r_fsm)
      S_ROUND: w_rk_idx = r_cnt;
      S_FINAL: w_rk_idx = 4'd0;
      default: ;
    endcase
  end

  assign w_busy = (r_fsm == S_INIT) || (r_fsm == S_ROUND) || (r_fsm == S_FINAL);
  assign w_done = (r_fsm == S_DONE);

  assign io_bus.rk_idx    = w_rk_idx;
  assign io_bus.plaintext = r_plaintext;
  assign io_bus.done      = w_done;
  assign io_bus.busy      = w_busy;

endmodule

// File: tb/tb_aes256_decrypt_core.sv
// ----------------------------------------------------------------------------
// tb_aes256_decrypt_core
// Directed bench for aes256_decrypt_core. Round keys come from a key-schedule
// model indexed by rk_idx; an independent forward AES-256 model (S-box derived
// from GF(2^8) inversion plus the affine map) produces round-trip vectors.
// ----------------------------------------------------------------------------
module tb_aes256_decrypt_core;

  localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C3_CT   = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] C3_PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] ZERO_CT = 128'hdc95c078a2408989ad48a21492842087;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  aes256_decrypt_core_if bus ();

  aes256_decrypt_core dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  logic [127:0] rk_mem [16];
  logic [7:0]   sbox_t [256];
  assign bus.rk_in = rk_mem[bus.rk_idx];

  int n_checks = 0;
  int n_fail   = 0;
  int busy_err;
  int stab_err;
  int rk_seq [$];
  logic done_after;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h01;
      repeat (254) inv = gmul(inv, 8'(x));
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
          {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox_t[x] = s;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  task automatic expand(input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rcon = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end else if (i % 8 == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-8] ^ t;
    end
    for (int r = 0; r < 15; r++) rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    rk_mem[15] = '0;
  endtask

  // Forward AES-256 using the current rk_mem schedule.
  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [127:0] s, o;
    logic [7:0]   a0, a1, a2, a3;
    s = pt ^ rk_mem[0];
    for (int rnd = 1; rnd < 15; rnd++) begin
      for (int k = 0; k < 16; k++) s[127-8*k -: 8] = sbox_t[s[127-8*k -: 8]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
      s = o;
      if (rnd < 14) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[127-32*c -: 8];
          a1 = s[119-32*c -: 8];
          a2 = s[111-32*c -: 8];
          a3 = s[103-32*c -: 8];
          o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                               a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                               a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                               xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
        end
        s = o;
      end
      s = s ^ rk_mem[rnd];
    end
    return s;
  endfunction

  // Issues one request from IDLE and follows it to DONE. lat counts edges
  // from the accepting edge to the cycle where done is seen.
  task automatic run_decrypt(input logic [127:0] ct, input logic [127:0] prev_pt,
                             output logic [127:0] pt, output int lat);
    rk_seq.delete();
    busy_err = 0;
    stab_err = 0;
    bus.ciphertext = ct;
    bus.start      = 1'b1;
    rk_seq.push_back(int'(bus.rk_idx));
    tick();
    bus.start      = 1'b0;
    bus.ciphertext = ~ct;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      rk_seq.push_back(int'(bus.rk_idx));
      if (bus.busy !== 1'b1) busy_err++;
      if (bus.plaintext !== prev_pt) stab_err++;
      tick();
      lat++;
    end
    rk_seq.push_back(int'(bus.rk_idx));
    if (bus.busy !== 1'b0) busy_err++;
    pt = bus.plaintext;
    tick();
    done_after = bus.done;
  endtask

  initial begin
    logic [127:0] got, prev, rt_pt, rt_ct;
    logic [255:0] rt_key;
    int lat, w, bb, stab_total, lat_bad;
    int done_edges [$];
    int rk_exp [17] = '{14, 14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 14};

    build_sbox();
    rst_n          = 1'b0;
    bus.start      = 1'b1;
    bus.ciphertext = C3_CT;
    expand(C3_KEY);

    // Reset held with start asserted: reset values must stay put.
    repeat (3) tick();
    check("rst_plaintext", bus.plaintext, '0);
    check("rst_done", 128'(bus.done), 128'd0);
    check("rst_busy", 128'(bus.busy), 128'd0);
    check("rst_rk_idx", 128'(bus.rk_idx), 128'd14);

    bus.start = 1'b0;
    rst_n     = 1'b1;
    repeat (3) tick();
    check("idle_busy", 128'(bus.busy), 128'd0);
    check("idle_rk_idx", 128'(bus.rk_idx), 128'd14);
    check("idle_plaintext", bus.plaintext, '0);

    // FIPS-197 C.3
    run_decrypt(C3_CT, '0, got, lat);
    check("c3_plaintext", got, C3_PT);
    check("c3_latency", 128'(lat), 128'd15);
    check("c3_busy_profile", 128'(busy_err), 128'd0);
    check("c3_plaintext_hold", 128'(stab_err), 128'd0);
    check("c3_done_one_cycle", 128'(done_after), 128'd0);

    // All-zero key
    expand('0);
    run_decrypt(ZERO_CT, C3_PT, got, lat);
    check("zero_plaintext", got, '0);
    check("zero_latency", 128'(lat), 128'd15);
    check("zero_rk_seq_len", 128'(rk_seq.size()), 128'd17);
    for (int j = 0; j < 17 && j < rk_seq.size(); j++)
      check($sformatf("zero_rk_idx_%0d", j), 128'(rk_seq[j]), 128'(rk_exp[j]));

    // start held high for 40 cycles; second acceptance is the IDLE after DONE.
    expand(C3_KEY);
    bus.ciphertext = C3_CT;
    bus.start      = 1'b1;
    bb = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done === 1'b1) done_edges.push_back(i);
      if (bus.busy !== !(i == 15 || i == 16 || i == 32 || i == 33)) bb++;
    end
    bus.start = 1'b0;
    check("ign_done_count", 128'(done_edges.size()), 128'd2);
    check("ign_done_first", 128'(done_edges[0]), 128'd15);
    check("ign_done_second", 128'(done_edges[1]), 128'd32);
    check("ign_busy_profile", 128'(bb), 128'd0);
    check("ign_plaintext", bus.plaintext, C3_PT);
    w = 0;
    while (bus.done !== 1'b1 && w < 40) begin
      tick();
      w++;
    end
    check("ign_third_done", 128'(bus.done), 128'd1);
    check("ign_third_plaintext", bus.plaintext, C3_PT);
    tick();

    // Reset in the middle of ROUND (counter = 7).
    bus.ciphertext = C3_CT;
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
    w = 0;
    while (bus.rk_idx !== 4'd7 && w < 20) begin
      tick();
      w++;
    end
    check("mid_reach_round7", 128'(bus.rk_idx), 128'd7);
    check("mid_busy_before", 128'(bus.busy), 128'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_plaintext", bus.plaintext, '0);
    check("mid_rst_done", 128'(bus.done), 128'd0);
    check("mid_rst_busy", 128'(bus.busy), 128'd0);
    check("mid_rst_rk_idx", 128'(bus.rk_idx), 128'd14);
    bus.start = 1'b1;
    repeat (2) tick();
    check("mid_rst_hold_busy", 128'(bus.busy), 128'd0);
    bus.start = 1'b0;
    rst_n     = 1'b1;
    run_decrypt(C3_CT, '0, got, lat);
    check("mid_after_plaintext", got, C3_PT);
    check("mid_after_latency", 128'(lat), 128'd15);

    // Round trip against the forward model.
    prev       = C3_PT;
    stab_total = 0;
    lat_bad    = 0;
    for (int n = 0; n < 1000; n++) begin
      rt_key = {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
      rt_pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
      expand(rt_key);
      rt_ct = encrypt(rt_pt);
      run_decrypt(rt_ct, prev, got, lat);
      check($sformatf("rt_plaintext_%0d", n), got, rt_pt);
      stab_total += stab_err;
      if (lat != 15) lat_bad++;
      prev = rt_pt;
    end
    check("rt_plaintext_hold", 128'(stab_total), 128'd0);
    check("rt_latency", 128'(lat_bad), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
